// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction memory program loader.
package loader_pkg;

    localparam int unsigned LOADER_DEPTH = 64;
    localparam int unsigned WORD_W       = 16;
    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned COUNT_W      = 7;

    // Byte-order encodings for the HIGH_FIRST parameter
    localparam bit ORDER_HIGH_FIRST = 1'b1;
    localparam bit ORDER_LOW_FIRST  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_WORD,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } loader_state_e;

    typedef struct packed {
        logic [BYTE_W-1:0] hi;
        logic [BYTE_W-1:0] lo;
    } instr_word_t;

    // Byte for a given position: the high half when order and position agree
    function automatic logic [BYTE_W-1:0] pick_byte(instr_word_t w, bit high_first, logic second);
        return (high_first ^ second) ? w.hi : w.lo;
    endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Host word handshake between the word source and the loader.
interface instruction_loader_if;
    import loader_pkg::*;

    instr_word_t word_in;
    logic        word_valid;
    logic        word_ready;

    modport master (output word_in, output word_valid, input word_ready);
    modport slave  (input word_in, input word_valid, output word_ready);

endinterface

// File: rtl/strobe_timer.sv
// Loadable down-counter with a terminal-count flag, timing strobe and gap phases.
module strobe_timer #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload on phase entry, otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (load) begin
                cnt_d = load_val;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Last enabled cycle of the current phase
    assign done_c = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/instruction_loader.sv
// Splits 16-bit host words into two strobed bytes for the instruction memory load port.
module instruction_loader
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH         = LOADER_DEPTH,
    parameter int unsigned STROBE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES    = 4,
    parameter bit          HIGH_FIRST    = ORDER_HIGH_FIRST
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clk_enable,
    input  logic                      load_start,
    input  logic                      load_end,
    instruction_loader_if.slave       host,
    output logic [BYTE_W-1:0]         load_byte,
    output logic                      load_strobe,
    output logic [COUNT_W-1:0]        word_count,
    output logic                      busy,
    output logic                      load_done
);

    localparam int unsigned MAX_CYC = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

    loader_state_e      state_q,  state_d;
    instr_word_t        word_q,   word_d;
    logic               second_q, second_d;
    logic               end_q,    end_d;
    logic [COUNT_W-1:0] count_q,  count_d;
    logic [BYTE_W-1:0]  byte_q,   byte_d;
    logic               strobe_q, strobe_d;
    logic               ready_q,  ready_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    logic               timer_load_c;
    logic [CNT_W-1:0]   timer_val_c;
    logic               timer_done_c;

    strobe_timer #(
        .CNT_W (CNT_W)
    ) u_strobe_timer (
        .clk      (clk),
        .reset    (reset),
        .en       (clk_enable),
        .load     (timer_load_c),
        .load_val (timer_val_c),
        .done_c   (timer_done_c)
    );

    // Next-state, datapath and registered-output selection
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        second_d     = second_q;
        end_d        = end_q;
        count_d      = count_q;
        byte_d       = byte_q;
        timer_load_c = 1'b0;
        timer_val_c  = CNT_W'(STROBE_CYCLES);

        if (clk_enable) begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (load_start) begin
                        state_d = ST_WAIT_WORD;
                        count_d = '0;
                        end_d   = 1'b0;
                    end
                end
                ST_WAIT_WORD: begin
                    if (host.word_valid && ready_q) begin
                        word_d   = host.word_in;
                        second_d = 1'b0;
                        byte_d   = pick_byte(host.word_in, HIGH_FIRST, 1'b0);
                        state_d  = ST_SETUP;
                        if (load_end) begin
                            end_d = 1'b1;
                        end
                    end else if (end_q || load_end) begin
                        state_d = ST_DONE;
                    end
                end
                ST_SETUP: begin
                    if (load_end) begin
                        end_d = 1'b1;
                    end
                    state_d      = ST_STROBE;
                    timer_load_c = 1'b1;
                    timer_val_c  = CNT_W'(STROBE_CYCLES);
                end
                ST_STROBE: begin
                    if (load_end) begin
                        end_d = 1'b1;
                    end
                    if (timer_done_c) begin
                        state_d      = ST_HOLD;
                        timer_load_c = 1'b1;
                        timer_val_c  = CNT_W'(GAP_CYCLES);
                    end
                end
                ST_HOLD: begin
                    if (load_end) begin
                        end_d = 1'b1;
                    end
                    if (timer_done_c) begin
                        if (!second_q) begin
                            second_d = 1'b1;
                            byte_d   = pick_byte(word_q, HIGH_FIRST, 1'b1);
                            state_d  = ST_SETUP;
                        end else begin
                            count_d = count_q + COUNT_W'(1);
                            if ((count_d == COUNT_W'(DEPTH)) || end_d) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d = ST_WAIT_WORD;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        ready_d  = (state_d == ST_WAIT_WORD);
        strobe_d = (state_d == ST_STROBE);
        busy_d   = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d   = (state_d == ST_DONE);
    end

    // State and output registers; reset wins over clk_enable
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            word_q   <= '0;
            second_q <= 1'b0;
            end_q    <= 1'b0;
            count_q  <= '0;
            byte_q   <= '0;
            strobe_q <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            second_q <= second_d;
            end_q    <= end_d;
            count_q  <= count_d;
            byte_q   <= byte_d;
            strobe_q <= strobe_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign host.word_ready = ready_q;
    assign load_byte       = byte_q;
    assign load_strobe     = strobe_q;
    assign word_count      = count_q;
    assign busy            = busy_q;
    assign load_done       = done_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized bench for instruction_loader with a phase-level reference model and pulse monitor.
module tb_instruction_loader;
    import loader_pkg::*;

    localparam int unsigned S        = 4;
    localparam int unsigned G        = 4;
    localparam int unsigned DEPTH_TB = 64;
    localparam int unsigned HALF     = 1 + S + G;
    localparam int unsigned WORD_CYC = 2 * HALF;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_BUSY = 2;
    localparam int M_DONE = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        load_start;
    logic        load_end;
    logic        word_valid;
    logic [15:0] hf_word;
    logic [15:0] lf_word;

    logic [7:0]  hf_byte,   lf_byte;
    logic        hf_strobe, lf_strobe;
    logic [6:0]  hf_count,  lf_count;
    logic        hf_busy,   lf_busy;
    logic        hf_done,   lf_done;

    instruction_loader_if hf_if ();
    instruction_loader_if lf_if ();

    assign hf_if.word_in    = hf_word;
    assign hf_if.word_valid = word_valid;
    assign lf_if.word_in    = lf_word;
    assign lf_if.word_valid = word_valid;

    always #5 clk = ~clk;

    instruction_loader #(
        .DEPTH (DEPTH_TB), .STROBE_CYCLES (S), .GAP_CYCLES (G), .HIGH_FIRST (1'b1)
    ) dut_hf (
        .clk (clk), .reset (reset), .clk_enable (clk_enable), .load_start (load_start),
        .load_end (load_end), .host (hf_if), .load_byte (hf_byte), .load_strobe (hf_strobe),
        .word_count (hf_count), .busy (hf_busy), .load_done (hf_done)
    );

    instruction_loader #(
        .DEPTH (DEPTH_TB), .STROBE_CYCLES (S), .GAP_CYCLES (G), .HIGH_FIRST (1'b0)
    ) dut_lf (
        .clk (clk), .reset (reset), .clk_enable (clk_enable), .load_start (load_start),
        .load_end (load_end), .host (lf_if), .load_byte (lf_byte), .load_strobe (lf_strobe),
        .word_count (lf_count), .busy (lf_busy), .load_done (lf_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a load is idle, waiting, delivering for WORD_CYC cycles, or done
    int         m_phase = M_IDLE;
    int         m_left  = 0;
    int         m_count = 0;
    bit         m_end   = 1'b0;
    bit         m_accept = 1'b0;
    logic [7:0] exp_bytes [$];

    // Pulse monitor state
    bit         mon_hi   = 1'b0;
    int         mon_len  = 0;
    logic [7:0] mon_byte = '0;
    logic       prev_strobe = 1'b0;
    logic [7:0] prev_byte   = '0;
    int         raw_hi = 0;
    int         acc_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_step();
        m_accept = 1'b0;
        if (reset) begin
            m_phase = M_IDLE;
            m_count = 0;
            m_end   = 1'b0;
            exp_bytes.delete();
        end else if (clk_enable) begin
            case (m_phase)
                M_IDLE, M_DONE: begin
                    if (load_start) begin
                        m_phase = M_WAIT;
                        m_count = 0;
                        m_end   = 1'b0;
                    end
                end
                M_WAIT: begin
                    if (word_valid) begin
                        m_accept = 1'b1;
                        exp_bytes.push_back(hf_word[15:8]);
                        exp_bytes.push_back(hf_word[7:0]);
                        m_left  = WORD_CYC;
                        m_phase = M_BUSY;
                        if (load_end) m_end = 1'b1;
                    end else if (load_end) begin
                        m_phase = M_DONE;
                    end
                end
                default: begin
                    if (load_end) m_end = 1'b1;
                    m_left--;
                    if (m_left == 0) begin
                        m_count++;
                        m_phase = (m_count == DEPTH_TB || m_end) ? M_DONE : M_WAIT;
                    end
                end
            endcase
        end
    endtask

    // Compare DUT outputs with the model and track strobe pulses
    task automatic sample_check();
        check("ready", 32'(hf_if.word_ready), 32'(m_phase == M_WAIT));
        check("busy",  32'(hf_busy), 32'(m_phase == M_WAIT || m_phase == M_BUSY));
        check("done",  32'(hf_done), 32'(m_phase == M_DONE));
        check("count", 32'(hf_count), 32'(m_count));
        if (reset) begin
            check("rst_strobe", 32'(hf_strobe), 32'(0));
            check("rst_byte", 32'(hf_byte), 32'(0));
            mon_hi = 1'b0;
        end else if (!clk_enable) begin
            check("frozen_strobe", 32'(hf_strobe), 32'(prev_strobe));
            check("frozen_byte", 32'(hf_byte), 32'(prev_byte));
        end else if (hf_strobe) begin
            if (!mon_hi) begin
                check("setup_stable", 32'(hf_byte), 32'(prev_byte));
                mon_hi   = 1'b1;
                mon_len  = 0;
                mon_byte = hf_byte;
            end else begin
                check("strobe_byte_stable", 32'(hf_byte), 32'(mon_byte));
            end
            mon_len++;
        end else if (mon_hi) begin
            mon_hi = 1'b0;
            check("pulse_len", 32'(mon_len), 32'(S));
            check("gap_byte_stable", 32'(hf_byte), 32'(mon_byte));
            if (exp_bytes.size() == 0) check("pulse_queue", 32'(exp_bytes.size()), 32'(1));
            else check("pulse_byte", 32'(mon_byte), 32'(exp_bytes.pop_front()));
        end
        if (hf_strobe) raw_hi++;
        prev_strobe = hf_strobe;
        prev_byte   = hf_byte;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        sample_check();
        if (m_accept) acc_cnt++;
    endtask

    // Hold word_valid until the model sees n more acceptances, bounded by budget
    task automatic wait_accepts(input int n, input int budget, input bit rand_words);
        int target;
        target = acc_cnt + n;
        word_valid = 1'b1;
        for (int i = 0; i < budget && acc_cnt < target; i++) begin
            cycle();
            if (rand_words) hf_word = 16'($urandom);
        end
        check("accept_timeout", 32'(acc_cnt), 32'(target));
        word_valid = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        cycle();
        load_start = 1'b0;
    endtask

    task automatic finish_load();
        load_end = 1'b1;
        cycle();
        load_end = 1'b0;
        check("finish_done", 32'(hf_done), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int j;
        reset = 1'b1; clk_enable = 1'b1; load_start = 1'b0; load_end = 1'b0;
        word_valid = 1'b0; hf_word = '0; lf_word = 16'h1234;

        // Reset state
        cycle(); cycle();
        reset = 1'b0;
        cycle();
        check("rst_ready", 32'(hf_if.word_ready), 32'(0));
        check("rst_count", 32'(hf_count), 32'(0));

        // Single word with both byte orders, exact cycle pattern
        pulse_start();
        hf_word = 16'hA5C3;
        wait_accepts(1, 20, 1'b0);
        for (int i = 0; i < int'(WORD_CYC); i++) begin
            j = i % int'(HALF);
            check("dir_hf_strobe", 32'(hf_strobe), 32'(j >= 1 && j <= int'(S)));
            check("dir_lf_strobe", 32'(lf_strobe), 32'(j >= 1 && j <= int'(S)));
            check("dir_hf_byte", 32'(hf_byte), (i < int'(HALF)) ? 32'h0A5 : 32'h0C3);
            check("dir_lf_byte", 32'(lf_byte), (i < int'(HALF)) ? 32'h034 : 32'h012);
            cycle();
        end
        check("dir_ready_back", 32'(hf_if.word_ready), 32'(1));
        check("dir_count", 32'(hf_count), 32'(1));
        check("dir_lf_ready", 32'(lf_if.word_ready), 32'(1));
        check("dir_lf_count", 32'(lf_count), 32'(1));
        check("dir_lf_busy", 32'(lf_busy), 32'(1));
        check("dir_lf_done", 32'(lf_done), 32'(0));
        finish_load();

        // Full memory: 64 back-to-back words, then extra valid is refused
        pulse_start();
        hf_word = 16'($urandom);
        word_valid = 1'b1;
        for (int i = 0; i < int'(DEPTH_TB * WORD_CYC) + 200 && m_phase != M_DONE; i++) begin
            cycle();
            hf_word = 16'($urandom);
        end
        check("full_count", 32'(hf_count), 32'(DEPTH_TB));
        check("full_done", 32'(hf_done), 32'(1));
        repeat (20) cycle();
        word_valid = 1'b0;
        check("full_ready_low", 32'(hf_if.word_ready), 32'(0));
        check("full_drained", 32'(exp_bytes.size()), 32'(0));

        // load_end during the first strobe of word 3
        pulse_start();
        wait_accepts(3, 3 * int'(WORD_CYC) + 20, 1'b1);
        cycle();
        check("end_in_strobe", 32'(hf_strobe), 32'(1));
        load_end = 1'b1;
        cycle();
        load_end = 1'b0;
        word_valid = 1'b1;
        repeat (2 * WORD_CYC) cycle();
        word_valid = 1'b0;
        check("end_count", 32'(hf_count), 32'(3));
        check("end_done", 32'(hf_done), 32'(1));
        check("end_drained", 32'(exp_bytes.size()), 32'(0));

        // clk_enable toggling every cycle stretches each pulse to 8 clocks
        pulse_start();
        hf_word = 16'h5A3C;
        wait_accepts(1, 20, 1'b0);
        raw_hi = 0;
        for (int i = 0; i < 4 * int'(WORD_CYC); i++) begin
            clk_enable = ~clk_enable;
            cycle();
        end
        clk_enable = 1'b1;
        check("toggle_raw_high", 32'(raw_hi), 32'(2 * 2 * S));
        check("toggle_count", 32'(hf_count), 32'(1));
        finish_load();

        // Reset in the middle of a strobe pulse, then reload
        pulse_start();
        hf_word = 16'($urandom);
        wait_accepts(1, 20, 1'b0);
        for (int i = 0; i < 10 && !hf_strobe; i++) cycle();
        cycle();
        check("pre_reset_strobe", 32'(hf_strobe), 32'(1));
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("mid_rst_strobe", 32'(hf_strobe), 32'(0));
        check("mid_rst_count", 32'(hf_count), 32'(0));
        check("mid_rst_busy", 32'(hf_busy), 32'(0));
        cycle();
        pulse_start();
        hf_word = 16'hFFFF;
        wait_accepts(1, 20, 1'b0);
        repeat (WORD_CYC + 2) cycle();
        check("ff_count", 32'(hf_count), 32'(1));
        check("ff_byte", 32'(hf_byte), 32'h0FF);
        check("ff_drained", 32'(exp_bytes.size()), 32'(0));
        finish_load();

        // Random traffic with sparse enable, starts and ends
        for (int i = 0; i < 600; i++) begin
            clk_enable = ($urandom_range(0, 3) != 0);
            word_valid = 1'($urandom);
            hf_word    = 16'($urandom);
            load_end   = ($urandom_range(0, 59) == 0);
            load_start = ($urandom_range(0, 29) == 0);
            cycle();
        end
        clk_enable = 1'b1; word_valid = 1'b0; load_end = 1'b0; load_start = 1'b0;
        repeat (WORD_CYC + 2) cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
